// File: rtl/program_counter_pkg.sv
// Shared constants for the 6502 program counter slice: address and byte
// widths, and the default value loaded into PCH:PCL on reset.
package program_counter_pkg;

  localparam int PC_WIDTH  = 16;
  localparam int PCL_WIDTH = 8;
  localparam int PCH_WIDTH = 8;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;

endpackage : program_counter_pkg

// File: rtl/program_counter_pc_byte.sv
// One byte of the program counter.
// Holds an 8-bit register with a load mux, then adds a one-bit carry-in
// to the selected value. The carry-out is set when the carry-in is set
// and the selected value is 8'hFF, so the PCH byte sees the wrap of PCL.
module program_counter_pc_byte
  import program_counter_pkg::*;
#(
  parameter logic [PCL_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_i,
  input  logic [PCL_WIDTH-1:0] bus_i,
  input  logic                 cin_i,
  output logic [PCL_WIDTH-1:0] q_o,
  output logic                 cout_o
);

  logic [PCL_WIDTH-1:0] byte_q;
  logic [PCL_WIDTH-1:0] byte_d;
  logic [PCL_WIDTH-1:0] sel;

  // Select the bus or the held value, then add the carry-in (mod 256).
  always_comb begin
    sel    = ld_i ? bus_i : byte_q;
    byte_d = sel + {{(PCL_WIDTH-1){1'b0}}, cin_i};
    cout_o = cin_i & (&sel);
  end

  // Byte register; reset overrides load and increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_q <= RESET_VAL;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign q_o = byte_q;

endmodule : program_counter_pc_byte

// File: rtl/program_counter.sv
// 6502 program counter: PCL and PCH registers with PCLS/PCHS select muxes
// and a ripple incrementer from PCL into PCH. Loads from the resolved
// ADL/ADH buses and increments take effect on the next rising edge.
// Optional: define PROGRAM_COUNTER_PREV_PC_EN to add o_pc_prev, which
// captures the old PCH:PCL whenever either byte is loaded from a bus.
module program_counter
  import program_counter_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [PCL_WIDTH-1:0] i_bus_adl,
  input  logic [PCH_WIDTH-1:0] i_bus_adh,
  input  logic                 i_adl_pcl,
  input  logic                 i_adh_pch,
  input  logic                 i_i_pc,
  output logic [PCL_WIDTH-1:0] o_pcl,
  output logic [PCH_WIDTH-1:0] o_pch,
  output logic                 o_pcl_carry
`ifdef PROGRAM_COUNTER_PREV_PC_EN
  ,
  output logic [PC_WIDTH-1:0]  o_pc_prev
`endif
);

  logic pcl_cout;
  logic pch_cout_unused;
  logic carry_q;

  // PCL increments whenever i_i_pc is set.
  program_counter_pc_byte #(
    .RESET_VAL (RESET_PC[PCL_WIDTH-1:0])
  ) u_pcl (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .ld_i   (i_adl_pcl),
    .bus_i  (i_bus_adl),
    .cin_i  (i_i_pc),
    .q_o    (o_pcl),
    .cout_o (pcl_cout)
  );

  // PCH takes the PCL carry, so a carry out of a freshly loaded PCL still
  // ripples into an unloaded PCH.
  program_counter_pc_byte #(
    .RESET_VAL (RESET_PC[PC_WIDTH-1:PCL_WIDTH])
  ) u_pch (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .ld_i   (i_adh_pch),
    .bus_i  (i_bus_adh),
    .cin_i  (pcl_cout),
    .q_o    (o_pch),
    .cout_o (pch_cout_unused)
  );

  // Register the PCL carry; it is zero on any cycle without an increment.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= pcl_cout;
    end
  end

  assign o_pcl_carry = carry_q;

`ifdef PROGRAM_COUNTER_PREV_PC_EN
  logic [PC_WIDTH-1:0] pc_prev_q;

  // Capture the outgoing PC on any bus load (jump, branch, vector fetch).
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pc_prev_q <= RESET_PC;
    end else if (i_adl_pcl || i_adh_pch) begin
      pc_prev_q <= {o_pch, o_pcl};
    end
  end

  assign o_pc_prev = pc_prev_q;
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver pushes the expected PC,
// carry and previous-PC values for every edge it drives; a monitor pops and
// compares one entry after each rising edge.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bus_adl;
  logic [7:0]  bus_adh;
  logic        adl_pcl;
  logic        adh_pch;
  logic        i_pc;
  logic [7:0]  pcl;
  logic [7:0]  pch;
  logic        pcl_carry;
`ifdef PROGRAM_COUNTER_PREV_PC_EN
  logic [15:0] pc_prev;
`endif

  always #5 clk = ~clk;

  program_counter #(
    .RESET_PC (16'h0000)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_bus_adl   (bus_adl),
    .i_bus_adh   (bus_adh),
    .i_adl_pcl   (adl_pcl),
    .i_adh_pch   (adh_pch),
    .i_i_pc      (i_pc),
    .o_pcl       (pcl),
    .o_pch       (pch),
    .o_pcl_carry (pcl_carry)
`ifdef PROGRAM_COUNTER_PREV_PC_EN
    ,
    .o_pc_prev   (pc_prev)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        carry;
    logic [15:0] prev;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Monitor: one expectation per driven edge, sampled 1 time unit later.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pch, pcl} === e.pc) passes++;
      else $display("FAIL %s pc got %h want %h", e.name, {pch, pcl}, e.pc);
      checks++;
      if (pcl_carry === e.carry) passes++;
      else $display("FAIL %s carry got %b want %b", e.name, pcl_carry, e.carry);
`ifdef PROGRAM_COUNTER_PREV_PC_EN
      checks++;
      if (pc_prev === e.prev) passes++;
      else $display("FAIL %s prev got %h want %h", e.name, pc_prev, e.prev);
`endif
    end
  end

  // Drive one edge worth of controls and queue what must appear after it.
  task automatic step(input string name, input logic rn, input logic ld_l,
                      input logic ld_h, input logic inc, input logic [7:0] bl,
                      input logic [7:0] bh, input logic [15:0] epc,
                      input logic ec, input logic [15:0] eprev);
    exp_t e;
    @(negedge clk);
    rst_n   = rn;
    adl_pcl = ld_l;
    adh_pch = ld_h;
    i_pc    = inc;
    bus_adl = bl;
    bus_adh = bh;
    e.name  = name;
    e.pc    = epc;
    e.carry = ec;
    e.prev  = eprev;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; adl_pcl = 1'b0; adh_pch = 1'b0; i_pc = 1'b0;
    bus_adl = 8'h00; bus_adh = 8'h00;

    // Reset held with active controls, then count up.
    step("rst0",    0, 1, 0, 1, 8'h55, 8'h00, 16'h0000, 0, 16'h0000);
    step("rst1",    0, 1, 0, 1, 8'h55, 8'h00, 16'h0000, 0, 16'h0000);
    step("inc1",    1, 0, 0, 1, 8'h00, 8'h00, 16'h0001, 0, 16'h0000);
    step("inc2",    1, 0, 0, 1, 8'h00, 8'h00, 16'h0002, 0, 16'h0000);
    step("inc3",    1, 0, 0, 1, 8'h00, 8'h00, 16'h0003, 0, 16'h0000);
    // Page cross.
    step("ld00fe",  1, 1, 1, 0, 8'hFE, 8'h00, 16'h00FE, 0, 16'h0003);
    step("pg_ff",   1, 0, 0, 1, 8'h00, 8'h00, 16'h00FF, 0, 16'h0003);
    step("pg_100",  1, 0, 0, 1, 8'h00, 8'h00, 16'h0100, 1, 16'h0003);
    step("pg_hold", 1, 0, 0, 0, 8'h00, 8'h00, 16'h0100, 0, 16'h0003);
    // Load with and without increment.
    step("ldinc",   1, 1, 1, 1, 8'h34, 8'h12, 16'h1235, 0, 16'h0100);
    step("ldonly",  1, 1, 1, 0, 8'h34, 8'h12, 16'h1234, 0, 16'h1235);
    // Partial load with carry into the old PCH, then PCH-only load.
    step("ld12a0",  1, 1, 1, 0, 8'hA0, 8'h12, 16'h12A0, 0, 16'h1234);
    step("pl_cry",  1, 1, 0, 1, 8'hFF, 8'h77, 16'h1300, 1, 16'h12A0);
    step("ph_only", 1, 0, 1, 0, 8'h99, 8'h80, 16'h8000, 0, 16'h1300);
    // Wrap-around and hold.
    step("ldffff",  1, 1, 1, 0, 8'hFF, 8'hFF, 16'hFFFF, 0, 16'h8000);
    step("wrap",    1, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 1, 16'h8000);
    for (int i = 0; i < 4; i++)
      step("wr_hold", 1, 0, 0, 0, 8'hAA, 8'hBB, 16'h0000, 0, 16'h8000);
    // Reset in the middle of a load discards it.
    step("ld5678",  1, 1, 1, 0, 8'h78, 8'h56, 16'h5678, 0, 16'h0000);
    step("rst_mid", 0, 1, 1, 1, 8'h34, 8'h12, 16'h0000, 0, 16'h0000);
    step("post_rs", 1, 0, 0, 1, 8'h00, 8'h00, 16'h0001, 0, 16'h0000);
    // Jump trace: load 0203, jump to 4000, then increment.
    step("ld0203",  1, 1, 1, 0, 8'h03, 8'h02, 16'h0203, 0, 16'h0001);
    step("ld4000",  1, 1, 1, 0, 8'h00, 8'h40, 16'h4000, 0, 16'h0203);
    step("tr_inc1", 1, 0, 0, 1, 8'h00, 8'h00, 16'h4001, 0, 16'h0203);
    step("tr_inc2", 1, 0, 0, 1, 8'h00, 8'h00, 16'h4002, 0, 16'h0203);
    step("tr_inc3", 1, 0, 0, 1, 8'h00, 8'h00, 16'h4003, 0, 16'h0203);
    step("tr_inc4", 1, 0, 0, 1, 8'h00, 8'h00, 16'h4004, 0, 16'h0203);
    step("tr_inc5", 1, 0, 0, 1, 8'h00, 8'h00, 16'h4005, 0, 16'h0203);

    @(negedge clk);
    i_pc = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_program_counter
